// File: rtl/rv_decode_stage.sv
// rv_decode_stage: registered RISC-V RV32I/RV64I decode stage with a 2-entry skid buffer
//
// Splits each accepted instruction into fields, builds the format-correct sign-extended
// immediate and flags encodings that are not legal for the configured XLEN. Decode runs
// on the input side; the result is stored with the entry, so the output path is register-only.
//
// Parameters
//   XLEN         32 or 64 (anything else stops elaboration)
//   ID_WIDTH     width of the opaque tag carried with each instruction
//
// Ports
//   clk, rst           clock, synchronous active-high reset
//   flush              drop every buffered entry (and the one offered this cycle)
//   in_valid/in_ready  fetch handshake; in_ready comes straight from a flop
//   in_inst/pc/id      raw instruction, its address and tag
//   out_valid/ready    issue handshake
//   out_pc/out_id      passthrough of the accepted address and tag
//   out_opcode/rd/rs1/rs2/funct3/funct7/funct12  instruction fields
//   out_imm            sign-extended immediate
//   out_illegal        encoding not legal for XLEN (entry still flows through)
//
// Optional feature, macro RV_DECODE_PERF_EN
//   perf_decoded/perf_illegal  32-bit wrapping counters of output transfers
//   (illegal transfers bump both); cleared by rst only, not by flush.
module rv_decode_stage #(
    parameter int XLEN     = 32,
    parameter int ID_WIDTH = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                flush,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [31:0]         in_inst,
    input  logic [XLEN-1:0]     in_pc,
    input  logic [ID_WIDTH-1:0] in_id,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [XLEN-1:0]     out_pc,
    output logic [ID_WIDTH-1:0] out_id,
    output logic [6:0]          out_opcode,
    output logic [4:0]          out_rd,
    output logic [4:0]          out_rs1,
    output logic [4:0]          out_rs2,
    output logic [2:0]          out_funct3,
    output logic [6:0]          out_funct7,
    output logic [11:0]         out_funct12,
    output logic [XLEN-1:0]     out_imm,
    output logic                out_illegal
`ifdef RV_DECODE_PERF_EN
    ,
    output logic [31:0]         perf_decoded,
    output logic [31:0]         perf_illegal
`endif
);
    if (XLEN != 32 && XLEN != 64) begin : g_xlen_chk
        $error("rv_decode_stage: XLEN must be 32 or 64");
    end

    localparam bit IS64 = (XLEN == 64);
    // entry layout, LSB first: inst, pc, id, imm, illegal
    localparam int EW = 32 + XLEN + ID_WIDTH + XLEN + 1;

    typedef enum logic [1:0] {S_EMPTY, S_ONE, S_TWO} state_t;

    state_t          r_state, w_next;
    logic            r_in_ready;
    logic [EW-1:0]   r_main, r_skid, w_in_ent;
    logic            w_acc, w_pop;
    logic [6:0]      w_op, w_f7, w_up;
    logic [2:0]      w_f3;
    logic [11:0]     w_f12;
    logic            w_s, w_legal_op, w_op_bad, w_w3_bad, w_illegal;
    logic [XLEN-1:0] w_imm;

    // shift-immediate rule: SLLI needs zero upper bits, SRLI/SRAI allow 0 or 0x20
    function automatic logic f_shift_bad(input logic [6:0] up, input logic [2:0] f3);
        return (f3 == 3'd1 && up != 7'h00) || (f3 == 3'd5 && up != 7'h00 && up != 7'h20);
    endfunction

    assign w_op  = in_inst[6:0];
    assign w_f3  = in_inst[14:12];
    assign w_f7  = in_inst[31:25];
    assign w_f12 = in_inst[31:20];
    assign w_s   = in_inst[31];
    // RV64 shamt is 6 bits, so only inst[31:26] are the "funct" bits; realign them to funct7
    assign w_up  = IS64 ? {in_inst[31:26], 1'b0} : in_inst[31:25];

    always_comb begin
        w_legal_op = 1'b0;
        case (w_op)
            7'h33, 7'h13, 7'h03, 7'h23, 7'h37, 7'h17,
            7'h6F, 7'h67, 7'h63, 7'h73, 7'h0F: w_legal_op = 1'b1;
            7'h1B, 7'h3B:                      w_legal_op = IS64;
            default:                           w_legal_op = 1'b0;
        endcase
    end

    assign w_op_bad = (w_f7 != 7'h00 && w_f7 != 7'h20) ||
                      (w_f7 == 7'h20 && w_f3 != 3'd0 && w_f3 != 3'd5);
    assign w_w3_bad = !(w_f3 == 3'd0 || w_f3 == 3'd1 || w_f3 == 3'd5);

    assign w_illegal = (in_inst[1:0] != 2'b11) || !w_legal_op
        || (w_op == 7'h67 && w_f3 != 3'd0)
        || (w_op == 7'h63 && (w_f3 == 3'd2 || w_f3 == 3'd3))
        || (w_op == 7'h03 && (IS64 ? w_f3 == 3'd7 : (w_f3 == 3'd3 || w_f3 == 3'd6 || w_f3 == 3'd7)))
        || (w_op == 7'h23 && w_f3 > (IS64 ? 3'd3 : 3'd2))
        || (w_op == 7'h33 && w_op_bad)
        || (w_op == 7'h13 && f_shift_bad(w_up, w_f3))
        || (w_op == 7'h1B && (w_w3_bad || f_shift_bad(w_f7, w_f3)))
        || (w_op == 7'h3B && (w_w3_bad || w_op_bad))
        || (w_op == 7'h73 && (w_f3 == 3'd4 || (w_f3 == 3'd0 && w_f12 > 12'd1)));

    // U-type sign bits come from inst[31], so replicating it over XLEN-31 bits is identical
    assign w_imm = (w_op == 7'h23) ? {{(XLEN-12){w_s}}, in_inst[31:25], in_inst[11:7]} :
                   (w_op == 7'h37 || w_op == 7'h17) ? {{(XLEN-31){w_s}}, in_inst[30:12], 12'b0} :
                   (w_op == 7'h6F) ? {{(XLEN-20){w_s}}, in_inst[19:12], in_inst[20], in_inst[30:21], 1'b0} :
                   (w_op == 7'h63) ? {{(XLEN-12){w_s}}, in_inst[7], in_inst[30:25], in_inst[11:8], 1'b0} :
                   {{(XLEN-12){w_s}}, in_inst[31:20]};

    assign w_in_ent = {w_illegal, w_imm, in_id, in_pc, in_inst};
    assign w_acc    = in_valid && r_in_ready;
    assign w_pop    = out_valid && out_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= S_EMPTY;
            r_in_ready <= 1'b1;
        end else begin
            r_state    <= w_next;
            r_in_ready <= (w_next != S_TWO);
        end
    end

    always_comb begin
        w_next = flush ? S_EMPTY :
                 (r_state == S_EMPTY) ? (w_acc ? S_ONE : S_EMPTY) :
                 (r_state == S_ONE)   ? ((w_acc && !w_pop) ? S_TWO : (w_pop && !w_acc) ? S_EMPTY : S_ONE) :
                 (w_pop ? S_ONE : S_TWO);
    end

    always_comb begin
        out_valid = (r_state != S_EMPTY);
        in_ready  = r_in_ready;
    end

    // main feeds the output; skid only fills when main is held and a new entry arrives
    always_ff @(posedge clk) begin
        if (rst) begin
            r_main <= '0;
            r_skid <= '0;
        end else if (!flush) begin
            if (w_acc && (r_state == S_EMPTY || w_pop))
                r_main <= w_in_ent;
            else if (r_state == S_TWO && w_pop)
                r_main <= r_skid;
            if (r_state == S_ONE && w_acc && !w_pop)
                r_skid <= w_in_ent;
        end
    end

    assign out_opcode  = r_main[6:0];
    assign out_rd      = r_main[11:7];
    assign out_funct3  = r_main[14:12];
    assign out_rs1     = r_main[19:15];
    assign out_rs2     = r_main[24:20];
    assign out_funct7  = r_main[31:25];
    assign out_funct12 = r_main[31:20];
    assign out_pc      = r_main[32 +: XLEN];
    assign out_id      = r_main[32+XLEN +: ID_WIDTH];
    assign out_imm     = r_main[32+XLEN+ID_WIDTH +: XLEN];
    assign out_illegal = r_main[EW-1];

`ifdef RV_DECODE_PERF_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            perf_decoded <= '0;
            perf_illegal <= '0;
        end else if (w_pop) begin
            perf_decoded <= perf_decoded + 32'd1;
            if (out_illegal)
                perf_illegal <= perf_illegal + 32'd1;
        end
    end
`endif
endmodule

// File: tb/tb_rv_decode_stage.sv
// tb_rv_decode_stage: directed table-driven bench for rv_decode_stage, XLEN=32 and XLEN=64 side by side
module tb_rv_decode_stage;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst = 1'b1, flush = 1'b0, in_valid = 1'b0, out_ready = 1'b1;
    logic [31:0] in_inst = '0;
    logic [63:0] in_pc = '0;
    logic [3:0]  in_id = '0;

    logic        a_in_ready, a_out_valid, a_ill, b_in_ready, b_out_valid, b_ill;
    logic [31:0] a_pc, a_imm;
    logic [63:0] b_pc, b_imm;
    logic [3:0]  a_id, b_id;
    logic [6:0]  a_op, a_f7, b_op, b_f7;
    logic [4:0]  a_rd, a_rs1, a_rs2, b_rd, b_rs1, b_rs2;
    logic [2:0]  a_f3, b_f3;
    logic [11:0] a_f12, b_f12;
`ifdef RV_DECODE_PERF_EN
    logic [31:0] a_pd, a_pi, b_pd, b_pi;
`endif

    rv_decode_stage #(.XLEN(32), .ID_WIDTH(4)) u32 (
        .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(a_in_ready),
        .in_inst(in_inst), .in_pc(in_pc[31:0]), .in_id(in_id), .out_valid(a_out_valid),
        .out_ready(out_ready), .out_pc(a_pc), .out_id(a_id), .out_opcode(a_op), .out_rd(a_rd),
        .out_rs1(a_rs1), .out_rs2(a_rs2), .out_funct3(a_f3), .out_funct7(a_f7),
        .out_funct12(a_f12), .out_imm(a_imm), .out_illegal(a_ill)
`ifdef RV_DECODE_PERF_EN
        , .perf_decoded(a_pd), .perf_illegal(a_pi)
`endif
    );

    rv_decode_stage #(.XLEN(64), .ID_WIDTH(4)) u64 (
        .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(b_in_ready),
        .in_inst(in_inst), .in_pc(in_pc), .in_id(in_id), .out_valid(b_out_valid),
        .out_ready(out_ready), .out_pc(b_pc), .out_id(b_id), .out_opcode(b_op), .out_rd(b_rd),
        .out_rs1(b_rs1), .out_rs2(b_rs2), .out_funct3(b_f3), .out_funct7(b_f7),
        .out_funct12(b_f12), .out_imm(b_imm), .out_illegal(b_ill)
`ifdef RV_DECODE_PERF_EN
        , .perf_decoded(b_pd), .perf_illegal(b_pi)
`endif
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    typedef struct {
        logic [31:0] inst;
        logic [63:0] imm;
        logic        ill32;
        logic        ill64;
    } vec_t;

    localparam int NV = 25;
    vec_t v[NV];

    task automatic check_vec(input int i, input logic [63:0] pc, input logic [3:0] id);
        logic [31:0] x;
        logic [63:0] e;
        x = v[i].inst;
        e = v[i].imm;
        chk($sformatf("v%0d valid32", i), a_out_valid, 1);
        chk($sformatf("v%0d valid64", i), b_out_valid, 1);
        chk($sformatf("v%0d opcode", i), a_op, x[6:0]);
        chk($sformatf("v%0d rd", i), a_rd, x[11:7]);
        chk($sformatf("v%0d rs1", i), a_rs1, x[19:15]);
        chk($sformatf("v%0d rs2", i), b_rs2, x[24:20]);
        chk($sformatf("v%0d funct3", i), b_f3, x[14:12]);
        chk($sformatf("v%0d funct7", i), a_f7, x[31:25]);
        chk($sformatf("v%0d funct12", i), b_f12, x[31:20]);
        chk($sformatf("v%0d imm32", i), a_imm, e[31:0]);
        chk($sformatf("v%0d imm64", i), b_imm, e);
        chk($sformatf("v%0d ill32", i), a_ill, v[i].ill32);
        chk($sformatf("v%0d ill64", i), b_ill, v[i].ill64);
        chk($sformatf("v%0d pc32", i), a_pc, pc[31:0]);
        chk($sformatf("v%0d pc64", i), b_pc, pc);
        chk($sformatf("v%0d id", i), a_id, id);
    endtask

    task automatic chk_both(input string name, input logic [3:0] id, input logic rdy, input logic vld);
        chk({name, " valid32"}, a_out_valid, vld);
        chk({name, " valid64"}, b_out_valid, vld);
        chk({name, " ready32"}, a_in_ready, rdy);
        chk({name, " ready64"}, b_in_ready, rdy);
        if (vld) begin
            chk({name, " id32"}, a_id, id);
            chk({name, " id64"}, b_id, id);
        end
    endtask

    task automatic offer(input logic [31:0] inst, input logic [3:0] id);
        in_valid = 1'b1;
        in_inst  = inst;
        in_id    = id;
        in_pc    = {60'h0, id} << 2;
    endtask

    initial begin
        v[0]  = '{32'hFFF00093, 64'hFFFFFFFF_FFFFFFFF, 1'b0, 1'b0};
        v[1]  = '{32'h123452B7, 64'h00000000_12345000, 1'b0, 1'b0};
        v[2]  = '{32'h800002B7, 64'hFFFFFFFF_80000000, 1'b0, 1'b0};
        v[3]  = '{32'hFFDFF0EF, 64'hFFFFFFFF_FFFFFFFC, 1'b0, 1'b0};
        v[4]  = '{32'h00002063, 64'h0,                 1'b1, 1'b1};
        v[5]  = '{32'h0020A423, 64'h8,                 1'b0, 1'b0};
        v[6]  = '{32'h0020B423, 64'h8,                 1'b1, 1'b0};
        v[7]  = '{32'hFE209EE3, 64'hFFFFFFFF_FFFFFFFC, 1'b0, 1'b0};
        v[8]  = '{32'h00003083, 64'h0,                 1'b1, 1'b0};
        v[9]  = '{32'h00007083, 64'h0,                 1'b1, 1'b1};
        v[10] = '{32'h02009093, 64'h20,                1'b1, 1'b0};
        v[11] = '{32'h4030D093, 64'h403,               1'b0, 1'b0};
        v[12] = '{32'h40001033, 64'h400,               1'b1, 1'b1};
        v[13] = '{32'h0000003B, 64'h0,                 1'b1, 1'b0};
        v[14] = '{32'h0000203B, 64'h0,                 1'b1, 1'b1};
        v[15] = '{32'h00000073, 64'h0,                 1'b0, 1'b0};
        v[16] = '{32'h00100073, 64'h1,                 1'b0, 1'b0};
        v[17] = '{32'h00200073, 64'h2,                 1'b1, 1'b1};
        v[18] = '{32'h00004073, 64'h0,                 1'b1, 1'b1};
        v[19] = '{32'h00000012, 64'h0,                 1'b1, 1'b1};
        v[20] = '{32'h00001067, 64'h0,                 1'b1, 1'b1};
        v[21] = '{32'h000080E7, 64'h0,                 1'b0, 1'b0};
        v[22] = '{32'hFFFFF117, 64'hFFFFFFFF_FFFFF000, 1'b0, 1'b0};
        v[23] = '{32'h0FF0000F, 64'hFF,                1'b0, 1'b0};
        v[24] = '{32'h0200D01B, 64'h20,                1'b1, 1'b1};

        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        chk_both("reset", 4'h0, 1'b1, 1'b0);
        chk("reset imm32", a_imm, 0);
        chk("reset imm64", b_imm, 0);
        chk("reset pc64", b_pc, 0);
        chk("reset opcode", a_op, 0);
        chk("reset ill", b_ill, 0);

        for (int i = 0; i < NV; i++) begin
            logic [63:0] pc;
            @(negedge clk);
            pc       = {32'hA5A50000, 32'h1000 + 32'(i * 4)};
            in_valid = 1'b1;
            in_inst  = v[i].inst;
            in_pc    = pc;
            in_id    = 4'(i);
            @(posedge clk);
            #1;
            in_valid = 1'b0;
            check_vec(i, pc, 4'(i));
        end
        @(posedge clk);
        #1;
        chk_both("drain", 4'h0, 1'b1, 1'b0);

        // back-pressure: A,B fill the buffer, C waits, then A,B,C drain in order
        @(negedge clk);
        out_ready = 1'b0;
        offer(32'hFFF00093, 4'd1);
        @(posedge clk); #1;
        chk_both("bp A", 4'd1, 1'b1, 1'b1);
        @(negedge clk);
        offer(32'h123452B7, 4'd2);
        @(posedge clk); #1;
        chk_both("bp B", 4'd1, 1'b0, 1'b1);
        @(negedge clk);
        offer(32'hFFDFF0EF, 4'd3);
        @(posedge clk); #1;
        chk_both("bp C held", 4'd1, 1'b0, 1'b1);
        chk("bp A imm stable", a_imm, 32'hFFFFFFFF);
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk); #1;
        chk_both("bp pop A", 4'd2, 1'b1, 1'b1);
        chk("bp B imm", b_imm, 64'h12345000);
        @(posedge clk); #1;
        in_valid = 1'b0;
        chk_both("bp pop B", 4'd3, 1'b1, 1'b1);
        chk("bp C imm", a_imm, 32'hFFFFFFFC);
        @(posedge clk); #1;
        chk_both("bp empty", 4'd0, 1'b1, 1'b0);

        // flush with two buffered and a new offer: everything gone, offer dropped
        @(negedge clk);
        out_ready = 1'b0;
        offer(32'h00000073, 4'd6);
        @(negedge clk);
        offer(32'h0020A423, 4'd7);
        @(negedge clk);
        chk_both("fl full", 4'd6, 1'b0, 1'b1);
        offer(32'h0FF0000F, 4'd8);
        flush = 1'b1;
        @(posedge clk); #1;
        chk_both("fl cycle", 4'd0, 1'b1, 1'b0);
        @(negedge clk);
        flush     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        chk_both("fl after", 4'd0, 1'b1, 1'b0);
        @(negedge clk);
        offer(32'hFE209EE3, 4'd9);
        @(posedge clk); #1;
        in_valid = 1'b0;
        chk_both("fl resume", 4'd9, 1'b1, 1'b1);
        chk("fl resume imm", b_imm, 64'hFFFFFFFF_FFFFFFFC);
        @(posedge clk); #1;

`ifdef RV_DECODE_PERF_EN
        begin
            int e32, e64;
            e32 = 0;
            e64 = 0;
            @(negedge clk);
            rst = 1'b1;
            @(negedge clk);
            rst = 1'b0;
            chk("perf rst dec", a_pd, 0);
            for (int i = 0; i < 10; i++) begin
                @(negedge clk);
                offer(v[i].inst, 4'(i));
                e32 += int'(v[i].ill32);
                e64 += int'(v[i].ill64);
                @(posedge clk); #1;
                in_valid = 1'b0;
            end
            @(negedge clk);
            flush = 1'b1;
            @(negedge clk);
            flush = 1'b0;
            chk("perf dec32", a_pd, 10);
            chk("perf dec64", b_pd, 10);
            chk("perf ill32", a_pi, 64'(e32));
            chk("perf ill64", b_pi, 64'(e64));
            rst = 1'b1;
            @(negedge clk);
            rst = 1'b0;
            chk("perf clr dec", b_pd, 0);
            chk("perf clr ill", a_pi, 0);
        end
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
